// File: rtl/median_filter_scalable.sv
// Streaming 3x3 median filter: one image row in per cycle, one filtered row of SIZE-2 pixels out.
// Define MEDIAN_PIPE_EN to register the per-column 3-sort (output latency 2 instead of 1).
module median_filter_scalable #(
  parameter int SIZE  = 100,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] arr_in  [SIZE-1:0],
  output logic             out_valid,
  output logic [WIDTH-1:0] arr_out [SIZE-3:0]
);

  typedef logic [WIDTH-1:0] pix_t;

  pix_t       row_a   [SIZE-1:0];
  pix_t       row_b   [SIZE-1:0];
  logic [1:0] cnt;
  logic       fire;

  pix_t col_lo  [SIZE-1:0];
  pix_t col_md  [SIZE-1:0];
  pix_t col_hi  [SIZE-1:0];
  pix_t src_lo  [SIZE-1:0];
  pix_t src_md  [SIZE-1:0];
  pix_t src_hi  [SIZE-1:0];
  pix_t win_med [SIZE-3:0];
  logic out_fire;

  function automatic pix_t min2(input pix_t x, input pix_t y);
    return (x < y) ? x : y;
  endfunction

  function automatic pix_t max2(input pix_t x, input pix_t y);
    return (x < y) ? y : x;
  endfunction

  function automatic pix_t min3(input pix_t x, input pix_t y, input pix_t z);
    return min2(min2(x, y), z);
  endfunction

  function automatic pix_t max3(input pix_t x, input pix_t y, input pix_t z);
    return max2(max2(x, y), z);
  endfunction

  function automatic pix_t med3(input pix_t x, input pix_t y, input pix_t z);
    return max2(min2(x, y), min2(max2(x, y), z));
  endfunction

  assign fire = in_valid && (cnt == 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        row_a[i] <= '0;
        row_b[i] <= '0;
      end
      cnt <= 2'd0;
    end else if (in_valid) begin
      row_a <= row_b;
      row_b <= arr_in;
      if (cnt != 2'd2) cnt <= cnt + 2'd1;
    end
  end

  // Each column of the window sorted once; neighbouring windows share these results.
  always_comb begin
    for (int c = 0; c < SIZE; c++) begin
      col_lo[c] = min3(row_a[c], row_b[c], arr_in[c]);
      col_md[c] = med3(row_a[c], row_b[c], arr_in[c]);
      col_hi[c] = max3(row_a[c], row_b[c], arr_in[c]);
    end
  end

`ifdef MEDIAN_PIPE_EN
  pix_t s_lo [SIZE-1:0];
  pix_t s_md [SIZE-1:0];
  pix_t s_hi [SIZE-1:0];
  logic s_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        s_lo[i] <= '0;
        s_md[i] <= '0;
        s_hi[i] <= '0;
      end
      s_valid <= 1'b0;
    end else begin
      s_valid <= fire;
      if (fire) begin
        s_lo <= col_lo;
        s_md <= col_md;
        s_hi <= col_hi;
      end
    end
  end

  assign src_lo   = s_lo;
  assign src_md   = s_md;
  assign src_hi   = s_hi;
  assign out_fire = s_valid;
`else
  assign src_lo   = col_lo;
  assign src_md   = col_md;
  assign src_hi   = col_hi;
  assign out_fire = fire;
`endif

  // Median of 9 from sorted columns: median of (max of mins, median of meds, min of maxes).
  always_comb begin
    for (int c = 0; c < SIZE - 2; c++) begin
      win_med[c] = med3(max3(src_lo[c], src_lo[c+1], src_lo[c+2]),
                        med3(src_md[c], src_md[c+1], src_md[c+2]),
                        min3(src_hi[c], src_hi[c+1], src_hi[c+2]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE - 2; i++) arr_out[i] <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_fire;
      if (out_fire) arr_out <= win_med;
    end
  end

endmodule

// File: tb/tb_median_filter_scalable.sv
// Bench for median_filter_scalable: directed cases on a 5-wide instance plus random rows on a 100-wide
// instance, both checked against a sort-based 3x3 median model.
module tb_median_filter_scalable;

  localparam int S = 5;
  localparam int L = 100;
`ifdef MEDIAN_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_s  [S-1:0];
  logic [7:0] out_s [S-3:0];
  logic       ov_s;
  logic [7:0] in_l  [L-1:0];
  logic [7:0] out_l [L-3:0];
  logic       ov_l;

  median_filter_scalable #(.SIZE(S), .WIDTH(8)) dut_s (
    .clk(tb_clk), .rst_n(rst_n), .in_valid(in_valid),
    .arr_in(in_s), .out_valid(ov_s), .arr_out(out_s));

  median_filter_scalable #(.SIZE(L), .WIDTH(8)) dut_l (
    .clk(tb_clk), .rst_n(rst_n), .in_valid(in_valid),
    .arr_in(in_l), .out_valid(ov_l), .arr_out(out_l));

  int n_tests = 0;
  int n_fail  = 0;
  int n_out_l = 0;

  // model state, index 0 = small instance, 1 = large instance
  int sz [2] = '{S, L};
  int nx [2][L];
  int ma [2][L];
  int mb [2][L];
  int mo [2][L];
  int pr [2][L];
  int cnt[2];
  bit mv [2];
  bit pv [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int med9(input int v[9]);
    int t[9];
    int x;
    t = v;
    for (int i = 1; i < 9; i++) begin
      x = t[i];
      for (int j = i; j > 0; j--) begin
        if (t[j-1] > x) begin
          t[j] = t[j-1];
          t[j-1] = x;
        end
      end
    end
    return t[4];
  endfunction

  task automatic model_edge(input bit v, input bit r);
    int row[L];
    int w[9];
    bit prod;
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        cnt[k] = 0; mv[k] = 0; pv[k] = 0;
        for (int i = 0; i < L; i++) begin
          ma[k][i] = 0; mb[k][i] = 0; mo[k][i] = 0; pr[k][i] = 0;
        end
      end else begin
        prod = v && (cnt[k] == 2);
        if (prod) begin
          for (int c = 0; c < sz[k] - 2; c++) begin
            for (int d = 0; d < 3; d++) begin
              w[3*d]   = ma[k][c+d];
              w[3*d+1] = mb[k][c+d];
              w[3*d+2] = nx[k][c+d];
            end
            row[c] = med9(w);
          end
        end
        if (LAT == 1) begin
          mv[k] = prod;
          if (prod) for (int c = 0; c < L; c++) mo[k][c] = row[c];
        end else begin
          mv[k] = pv[k];
          if (pv[k]) for (int c = 0; c < L; c++) mo[k][c] = pr[k][c];
          pv[k] = prod;
          if (prod) for (int c = 0; c < L; c++) pr[k][c] = row[c];
        end
        if (v) begin
          for (int i = 0; i < L; i++) begin
            ma[k][i] = mb[k][i];
            mb[k][i] = nx[k][i];
          end
          if (cnt[k] < 2) cnt[k]++;
        end
      end
    end
  endtask

  task automatic rnd_row(input int k);
    int mode;
    int base;
    mode = $urandom_range(0, 2);
    base = $urandom_range(0, 252);
    for (int i = 0; i < sz[k]; i++) begin
      case (mode)
        0:       nx[k][i] = $urandom_range(0, 255);
        1:       nx[k][i] = base + $urandom_range(0, 3);
        default: nx[k][i] = ($urandom_range(0, 9) == 0) ? 255 : base;
      endcase
    end
  endtask

  task automatic fill_s(input int val);
    for (int i = 0; i < S; i++) nx[0][i] = val;
  endtask

  task automatic set_s(input int v0, input int v1, input int v2, input int v3, input int v4);
    nx[0][0] = v0; nx[0][1] = v1; nx[0][2] = v2; nx[0][3] = v3; nx[0][4] = v4;
  endtask

  task automatic cyc(input bit v, input bit r);
    rnd_row(1);
    rst_n = r;
    in_valid = v;
    for (int i = 0; i < S; i++) in_s[i] = 8'(nx[0][i]);
    for (int i = 0; i < L; i++) in_l[i] = 8'(nx[1][i]);
    @(posedge tb_clk);
    model_edge(v, r);
    #1;
    chk("ov_s", ov_s, mv[0]);
    for (int c = 0; c < S - 2; c++) chk($sformatf("out_s[%0d]", c), out_s[c], mo[0][c]);
    chk("ov_l", ov_l, mv[1]);
    if (mv[1]) for (int c = 0; c < L - 2; c++) chk($sformatf("out_l[%0d]", c), out_l[c], mo[1][c]);
    if (ov_l === 1'b1) n_out_l++;
  endtask

  task automatic drain();
    repeat (LAT - 1) cyc(1'b0, 1'b1);
  endtask

  initial begin
    fill_s(0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("rst_ov", ov_s, 0);
    chk("rst_out", out_s[1], 0);

    // constant rows of 0x40
    fill_s(8'h40);
    repeat (3) cyc(1'b1, 1'b1);
    drain();
    chk("t1_ov", ov_s, 1);
    for (int c = 0; c < S - 2; c++) chk($sformatf("t1_out[%0d]", c), out_s[c], 8'h40);

    // bright row joins two 0x40 rows: majority wins
    fill_s(8'hFF);
    cyc(1'b1, 1'b1);
    drain();
    chk("t4_ov", ov_s, 1);
    for (int c = 0; c < S - 2; c++) chk($sformatf("t4_out[%0d]", c), out_s[c], 8'h40);

    // mixed rows; medians worked out by hand from the sorted windows
    cyc(1'b0, 1'b0);
    set_s(1, 2, 3, 4, 5);         cyc(1'b1, 1'b1);
    set_s(9, 8, 7, 6, 5);         cyc(1'b1, 1'b1);
    set_s(0, 0, 255, 255, 255);   cyc(1'b1, 1'b1);
    drain();
    chk("t2_ov", ov_s, 1);
    chk("t2_out0", out_s[0], 3);
    chk("t2_out1", out_s[1], 6);
    chk("t2_out2", out_s[2], 6);

    // single impulse removed
    cyc(1'b0, 1'b0);
    fill_s(8'h10);                cyc(1'b1, 1'b1);
    nx[0][2] = 8'hFF;             cyc(1'b1, 1'b1);
    fill_s(8'h10);                cyc(1'b1, 1'b1);
    drain();
    for (int c = 0; c < S - 2; c++) chk($sformatf("t3_out[%0d]", c), out_s[c], 8'h10);

    // gaps in in_valid
    cyc(1'b0, 1'b0);
    set_s(1, 2, 3, 4, 5);         cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b1);
    set_s(9, 8, 7, 6, 5);         cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("t5_noov", ov_s, 0);
    set_s(0, 0, 255, 255, 255);   cyc(1'b1, 1'b1);
    drain();
    chk("t5_ov", ov_s, 1);
    repeat (3) cyc(1'b0, 1'b1);
    chk("t5_idle_ov", ov_s, 0);
    chk("t5_hold", out_s[0], 3);

    // reset mid-stream discards stored rows
    fill_s(8'h80);                cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    fill_s(8'h20);                cyc(1'b1, 1'b1);
    fill_s(8'h30);                cyc(1'b1, 1'b1);
    chk("t6_noov", ov_s, 0);
    fill_s(8'h20);                cyc(1'b1, 1'b1);
    drain();
    chk("t6_ov", ov_s, 1);
    for (int c = 0; c < S - 2; c++) chk($sformatf("t6_out[%0d]", c), out_s[c], 8'h20);

    // random traffic with occasional resets
    for (int n = 0; n < 80; n++) begin
      rnd_row(0);
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) != 0));
    end

    // 100 back-to-back rows into the wide instance give 98 output rows
    cyc(1'b0, 1'b0);
    n_out_l = 0;
    for (int n = 0; n < 100; n++) begin
      rnd_row(0);
      cyc(1'b1, 1'b1);
    end
    drain();
    cyc(1'b0, 1'b1);
    chk("l_rows", n_out_l, 98);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
